// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - sequential AES MixColumns/InvMixColumns engine
//
// Transforms a 128-bit column-major AES state in place, COLS_PER_CYCLE
// columns per clock, using that many GF(2^8) column transformers.
//
// Parameters:
//   COLS_PER_CYCLE  columns transformed per clock (1, 2 or 4)
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_state/in_inverse valid
//   in_ready   out  block accepted this cycle when in_valid is high
//   in_state   in   128-bit state, column c at [127-32c -: 32], row r at [127-32c-8r -: 8]
//   in_inverse in   0 = MixColumns, 1 = InvMixColumns, latched at accept
//   out_valid  out  out_state holds a finished result
//   out_ready  in   downstream takes the result
//   out_state  out  transformed state, same layout
//   busy       out  high while columns are being transformed
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter step wraps to 0 for four columns per cycle; the group starting
    // at LAST_CNT is the final one of a block.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST_CNT = 2'((4 - COLS_PER_CYCLE) % 4);

    logic [1:0]   state;
    logic [127:0] w;
    logic         m;
    logic [1:0]   cnt;
    logic [127:0] next_w;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column transformer. Multiples 2, 4 and 8 come from chained xtime;
    // every other coefficient is an XOR of those and the plain byte.
    function automatic logic [31:0] col_xform(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] t2 [4];
        logic [7:0] t4 [4];
        logic [7:0] t8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            t2[i] = xtime(a[i]);
            t4[i] = xtime(t2[i]);
            t8[i] = xtime(t4[i]);
            m9[i] = t8[i] ^ a[i];
            mb[i] = t8[i] ^ t2[i] ^ a[i];
            md[i] = t8[i] ^ t4[i] ^ a[i];
            me[i] = t8[i] ^ t4[i] ^ t2[i];
        end
        if (!inv) begin
            return {t2[0] ^ t2[1] ^ a[1] ^ a[2] ^ a[3],
                    a[0] ^ t2[1] ^ t2[2] ^ a[2] ^ a[3],
                    a[0] ^ a[1] ^ t2[2] ^ t2[3] ^ a[3],
                    t2[0] ^ a[0] ^ a[1] ^ a[2] ^ t2[3]};
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Only the current column group is rewritten; the rest of w passes through.
    always_comb begin : p_next
        logic [1:0] idx;
        int         base;
        next_w = w;
        idx    = '0;
        base   = 127;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            idx  = cnt + 2'(j);
            base = 127 - 32 * int'(idx);
            next_w[base -: 32] = col_xform(w[base -: 32], m);
        end
    end

    // DONE hands off straight into a new block when downstream is taking the
    // result, so in_ready depends combinationally on out_ready.
    assign in_ready  = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == S_DONE);
    assign out_state = w;
    assign busy      = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            w     <= '0;
            m     <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        w     <= in_state;
                        m     <= in_inverse;
                        cnt   <= 2'd0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    w   <= next_w;
                    cnt <= cnt + STEP;
                    if (cnt == LAST_CNT) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (accept) begin
                        w     <= in_state;
                        m     <= in_inverse;
                        cnt   <= 2'd0;
                        state <= S_RUN;
                    end else if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb/tb_mix_columns_engine.sv - self-checking bench for mix_columns_engine (1, 2 and 4 columns per cycle)
module tb_mix_columns_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid_v   [3];
    logic         in_inverse_v [3];
    logic         out_ready_v  [3];
    logic [127:0] in_state_v   [3];
    logic         in_ready_v   [3];
    logic         out_valid_v  [3];
    logic         busy_v       [3];
    logic [127:0] out_state_v  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid_v[g]),
            .in_ready   (in_ready_v[g]),
            .in_state   (in_state_v[g]),
            .in_inverse (in_inverse_v[g]),
            .out_valid  (out_valid_v[g]),
            .out_ready  (out_ready_v[g]),
            .out_state  (out_state_v[g]),
            .busy       (busy_v[g])
        );
    end

    int           checks = 0;
    int           errors = 0;
    logic [127:0] sb [$];

    localparam logic [127:0] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_INV_IN  = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
    localparam logic [127:0] V_INV_OUT = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam logic [127:0] V_ML_IN   = 128'h2d26314c_2d26314c_2d26314c_2d26314c;
    localparam logic [127:0] V_ML_OUT  = 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8;

    // Reference model: generic shift-and-add GF(2^8) multiply and a
    // coefficient table rotated per output row.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   b;
        logic [127:0] r = '0;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(cf[(k - rr + 4) % 4], a[k]);
                r[127-32*c-8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [127:0] s, input logic inv, input logic [127:0] exp);
        int waited = 0;
        in_valid_v[d]   = 1'b1;
        in_state_v[d]   = s;
        in_inverse_v[d] = inv;
        while (!in_ready_v[d] && waited < 20) begin
            step;
            waited++;
        end
        check_bit($sformatf("in_ready_before_accept_d%0d", d), in_ready_v[d], 1'b1);
        step;
        in_valid_v[d] = 1'b0;
        sb.push_back(exp);
        check_bit($sformatf("busy_after_accept_d%0d", d), busy_v[d], 1'b1);
    endtask

    task automatic pop_and_check(input int d);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty_d%0d observed=%h expected=none", d, out_state_v[d]);
        end else begin
            check_vec($sformatf("out_state_d%0d", d), out_state_v[d], sb.pop_front());
        end
    endtask

    task automatic recv(input int d, input int lat);
        int cyc = 0;
        while (!out_valid_v[d] && cyc < 20) begin
            step;
            cyc++;
        end
        check_int($sformatf("latency_d%0d", d), cyc, lat);
        check_bit($sformatf("busy_in_done_d%0d", d), busy_v[d], 1'b0);
        check_bit($sformatf("in_ready_done_stalled_d%0d", d), in_ready_v[d], 1'b0);
        pop_and_check(d);
        out_ready_v[d] = 1'b1;
        step;
        out_ready_v[d] = 1'b0;
        check_bit($sformatf("out_valid_after_handshake_d%0d", d), out_valid_v[d], 1'b0);
    endtask

    initial begin
        logic [127:0] r;
        logic [127:0] held;
        logic         inv;
        logic         spurious;
        int           cyc;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid_v[d]   = 1'b0;
            in_inverse_v[d] = 1'b0;
            out_ready_v[d]  = 1'b0;
            in_state_v[d]   = '0;
        end
        step;
        step;
        for (int d = 0; d < 3; d++) begin
            check_bit($sformatf("reset_out_valid_d%0d", d), out_valid_v[d], 1'b0);
            check_vec($sformatf("reset_out_state_d%0d", d), out_state_v[d], '0);
            check_bit($sformatf("reset_busy_d%0d", d), busy_v[d], 1'b0);
            check_bit($sformatf("reset_in_ready_d%0d", d), in_ready_v[d], 1'b0);
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++)
            check_bit($sformatf("release_in_ready_d%0d", d), in_ready_v[d], 1'b1);
        step;

        // Directed vectors and a few random blocks on every width.
        for (int d = 0; d < 3; d++) begin
            send(d, V_FWD_IN, 1'b0, V_FWD_OUT);
            recv(d, 4 >> d);
            send(d, V_FWD_OUT, 1'b1, V_FWD_IN);
            recv(d, 4 >> d);
            send(d, V_INV_IN, 1'b1, V_INV_OUT);
            recv(d, 4 >> d);
            for (int n = 0; n < 3; n++) begin
                r   = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                send(d, r, inv, model(r, inv));
                recv(d, 4 >> d);
            end
        end

        // Backpressure, then same-cycle handoff to a new block.
        r = {$urandom, $urandom, $urandom, $urandom};
        send(0, r, 1'b0, model(r, 1'b0));
        cyc = 0;
        while (!out_valid_v[0] && cyc < 20) begin
            step;
            cyc++;
        end
        check_int("bp_latency", cyc, 4);
        held = out_state_v[0];
        for (int i = 0; i < 10; i++) begin
            step;
            check_vec("bp_out_state_stable", out_state_v[0], held);
            check_bit("bp_out_valid_held", out_valid_v[0], 1'b1);
            check_bit("bp_in_ready_low", in_ready_v[0], 1'b0);
        end
        r = {$urandom, $urandom, $urandom, $urandom};
        in_valid_v[0]   = 1'b1;
        in_state_v[0]   = r;
        in_inverse_v[0] = 1'b1;
        out_ready_v[0]  = 1'b1;
        #1;
        check_bit("handoff_in_ready", in_ready_v[0], 1'b1);
        pop_and_check(0);
        step;
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b0;
        sb.push_back(model(r, 1'b1));
        check_bit("handoff_out_valid_low", out_valid_v[0], 1'b0);
        check_bit("handoff_busy", busy_v[0], 1'b1);
        recv(0, 4);

        // Mode is latched at accept; in_inverse moves during RUN.
        send(0, V_ML_IN, 1'b0, V_ML_OUT);
        in_inverse_v[0] = 1'b1;
        in_state_v[0]   = ~V_ML_IN;
        recv(0, 4);
        in_inverse_v[0] = 1'b0;

        // Reset in the second RUN cycle aborts the block.
        send(0, V_FWD_IN, 1'b0, V_FWD_OUT);
        step;
        rst_n = 1'b0;
        step;
        check_bit("abort_out_valid", out_valid_v[0], 1'b0);
        check_vec("abort_out_state", out_state_v[0], '0);
        check_bit("abort_busy", busy_v[0], 1'b0);
        rst_n = 1'b1;
        #1;
        check_bit("abort_in_ready", in_ready_v[0], 1'b1);
        void'(sb.pop_back());
        spurious = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step;
            spurious = spurious | out_valid_v[0];
        end
        check_bit("abort_no_spurious_valid", spurious, 1'b0);
        r = {$urandom, $urandom, $urandom, $urandom};
        send(0, r, 1'b0, model(r, 1'b0));
        recv(0, 4);

        check_int("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
